// File: rtl/audio_i2s_tx_if.sv
// Sample handshake between the audio processing path and the I2S transmitter.
//   sample_l / sample_r : stereo PCM pair, two's complement
//   sample_valid        : pair is valid (source -> transmitter)
//   sample_ready        : transmitter holding buffer is empty (transmitter -> source)
interface audio_i2s_tx_if #(
    parameter int unsigned DATA_W = 18
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers one stereo pair from the handshake and serialises it
// MSB first with the standard one-bit delay after each word-select change.
//   clk, reset     : system clock, synchronous active-high reset
//   enable         : 1 runs the serial interface, 0 idles it (buffer kept)
//   s_if           : sample_l/sample_r/sample_valid in, sample_ready out
//   sck, ws, sd    : I2S bit clock, word select (0 = left), serial data
//   underrun       : 1-clk pulse when a frame starts with an empty buffer
//   done           : 1-clk pulse when the last bit of the right slot ends
module audio_i2s_tx #(
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned SLOT_W  = 32,
    parameter int unsigned CLK_DIV = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    audio_i2s_tx_if.slave s_if,
    output logic          sck,
    output logic          ws,
    output logic          sd,
    output logic          underrun,
    output logic          done
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

    // S_START: enabled or idle, waiting for the first falling sck edge
    typedef enum logic {S_START, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                slot_q, slot_d;
    logic                sck_q, sck_d;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic                underrun_q, underrun_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                full_q, full_d;
    logic [DATA_W-1:0]   buf_l_q, buf_l_d;
    logic [DATA_W-1:0]   buf_r_q, buf_r_d;
    logic [DATA_W-1:0]   word_l_q, word_l_d;
    logic [DATA_W-1:0]   word_r_q, word_r_d;

    logic                accept;
    logic                fall_tick;
    logic                load;
    logic [DATA_W-1:0]   sel_word;
    logic [DATA_W-1:0]   shifted;

    assign accept = s_if.sample_valid && ready_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_START;
            div_q      <= '0;
            bit_q      <= '0;
            slot_q     <= 1'b0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            full_q     <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            word_l_q   <= '0;
            word_r_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            slot_q     <= slot_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            full_q     <= full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            word_l_q   <= word_l_d;
            word_r_q   <= word_r_d;
        end
    end

    // Divider, slot sequencing, frame load, serial data and handshake
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        slot_d     = slot_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        sd_d       = sd_q;
        underrun_d = 1'b0;
        done_d     = 1'b0;
        full_d     = full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        word_l_d   = word_l_q;
        word_r_d   = word_r_q;
        load       = 1'b0;
        sel_word   = '0;
        shifted    = '0;
        fall_tick  = enable && sck_q && (div_q == DIV_W'(CLK_DIV - 1));

        if (!enable) begin
            state_d = S_START;
            div_d   = '0;
            bit_d   = '0;
            slot_d  = 1'b0;
            sck_d   = 1'b0;
            ws_d    = 1'b0;
            sd_d    = 1'b0;
        end else begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d = '0;
                sck_d = !sck_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            if (fall_tick) begin
                case (state_q)
                    S_START: begin
                        state_d = S_RUN;
                        bit_d   = '0;
                        slot_d  = 1'b0;
                        load    = 1'b1;
                    end
                    default: begin
                        if (bit_q == BIT_W'(SLOT_W - 1)) begin
                            bit_d  = '0;
                            slot_d = !slot_q;
                            // Leaving the right slot starts the next frame
                            load   = slot_q;
                            done_d = slot_q;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                endcase

                if (load) begin
                    word_l_d   = full_q ? buf_l_q : '0;
                    word_r_d   = full_q ? buf_r_q : '0;
                    underrun_d = !full_q;
                    full_d     = 1'b0;
                end

                // Bit b of a slot carries word[DATA_W-b]; right b=0 repeats the left LSB
                sel_word = slot_d ? word_r_d : word_l_d;
                shifted  = sel_word >> (DATA_W - int'(bit_d));
                ws_d     = slot_d;
                if ((int'(bit_d) >= 1) && (int'(bit_d) <= int'(DATA_W))) begin
                    sd_d = shifted[0];
                end else if (slot_d && (bit_d == '0)) begin
                    sd_d = word_l_d[0];
                end else begin
                    sd_d = 1'b0;
                end
            end
        end

        // Accept after load so a same-cycle accept lands in the emptied buffer
        if (accept) begin
            buf_l_d = s_if.sample_l;
            buf_r_d = s_if.sample_r;
            full_d  = 1'b1;
        end
        ready_d = !full_d;
    end

    assign sck               = sck_q;
    assign ws                = ws_q;
    assign sd                = sd_q;
    assign underrun          = underrun_q;
    assign done              = done_q;
    assign s_if.sample_ready = ready_q;
endmodule
